// File: rtl/pc_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and fetch-request generator. Presents the
//               fetch address to instruction memory over a valid/ready
//               handshake. Applies JAL/JALR/branch/trap redirects, halts on
//               a misaligned redirect target, and keeps a small circular
//               return-address stack (RAS) for the decoder.
// Ports       : clk, rstn (async active-low)
//               i_op, i_br_taken, i_imm_data, i_rs1_data, i_trap_vec : control
//               i_ras_push, i_ras_pop                                : RAS hints
//               o_req_valid / i_req_ready, o_pc                      : fetch port
//               o_ret_data (pc+4), o_imm_data (pc+imm)               : to execute
//               o_misalign, o_misalign_addr                          : fault info
//               o_ras_top, o_ras_valid                               : RAS view
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [2:0]      i_op,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_imm_data,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_ras_push,
    input  logic            i_ras_pop,
    output logic            o_req_valid,
    input  logic            i_req_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_ret_data,
    output logic [XLEN-1:0] o_imm_data,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_misalign_addr,
    output logic [XLEN-1:0] o_ras_top,
    output logic            o_ras_valid
);

    localparam logic [2:0] c_op_stop   = 3'd0;
    localparam logic [2:0] c_op_incr   = 3'd1;
    localparam logic [2:0] c_op_jal    = 3'd2;
    localparam logic [2:0] c_op_jalr   = 3'd3;
    localparam logic [2:0] c_op_branch = 3'd4;
    localparam logic [2:0] c_op_trap   = 3'd5;

    localparam logic [1:0] c_st_boot = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    localparam logic [XLEN-1:0] c_pc_step   = XLEN'(4);
    localparam logic [XLEN-1:0] c_jalr_mask = {{(XLEN-1){1'b1}}, 1'b0};

    localparam int c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);

    // ------------------------------------------------------------------
    // PC / control state
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_misalign;
    logic            w_misalign_nxt;
    logic [XLEN-1:0] r_misalign_addr;
    logic [XLEN-1:0] w_misalign_addr_nxt;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_target;
    logic            w_target_misaligned;
    logic            w_checked_redirect;

    assign w_seq_pc   = r_pc + c_pc_step;
    assign o_ret_data = w_seq_pc;
    assign o_imm_data = r_pc + i_imm_data;

    // Only the alignment-checked redirects use this target; traps load
    // i_trap_vec directly and are never checked.
    always_comb begin
        w_target = o_imm_data;
        if (i_op == c_op_jalr) begin
            w_target = (i_rs1_data + i_imm_data) & c_jalr_mask;
        end
    end

    generate
        if (IALIGN == 16) begin : g_ialign16
            assign w_target_misaligned = w_target[0];
        end else begin : g_ialign32
            assign w_target_misaligned = |w_target[1:0];
        end
    endgenerate

    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_misalign_nxt      = r_misalign;
        w_misalign_addr_nxt = r_misalign_addr;
        w_checked_redirect  = 1'b0;
        case (r_state)
            c_st_boot: begin
                w_state_nxt = c_st_run;
            end
            c_st_run: begin
                case (i_op)
                    c_op_incr: begin
                        if (i_req_ready) w_pc_nxt = w_seq_pc;
                    end
                    c_op_branch: begin
                        if (i_br_taken)       w_checked_redirect = 1'b1;
                        else if (i_req_ready) w_pc_nxt = w_seq_pc;
                    end
                    c_op_jal, c_op_jalr: begin
                        w_checked_redirect = 1'b1;
                    end
                    c_op_trap: begin
                        w_pc_nxt = i_trap_vec;
                    end
                    default: ; // stop and illegal ops hold the pc
                endcase
                // Redirects ignore i_req_ready: any pending request is dropped.
                if (w_checked_redirect) begin
                    if (w_target_misaligned) begin
                        w_misalign_nxt      = 1'b1;
                        w_misalign_addr_nxt = w_target;
                        w_state_nxt         = c_st_halt;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end
            end
            c_st_halt: begin
                if (i_op == c_op_trap) begin
                    w_pc_nxt       = i_trap_vec;
                    w_misalign_nxt = 1'b0;
                    w_state_nxt    = c_st_run;
                end
            end
            default: begin
                w_state_nxt = c_st_boot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= c_st_boot;
            r_pc            <= RESET_VECTOR;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_misalign      <= w_misalign_nxt;
            r_misalign_addr <= w_misalign_addr_nxt;
        end
    end

    assign o_pc            = r_pc;
    assign o_req_valid     = (r_state == c_st_run);
    assign o_misalign      = r_misalign;
    assign o_misalign_addr = r_misalign_addr;

    // ------------------------------------------------------------------
    // Return-address stack: circular buffer, top pointer plus fill count.
    // On overflow the pointer simply wraps, overwriting the oldest entry.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]    r_ras [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_ras_top;
    logic [c_ptr_w-1:0] w_top_inc;
    logic [c_ptr_w-1:0] w_top_dec;
    logic [c_cnt_w-1:0] r_ras_cnt;
    logic               w_ras_en;
    logic               w_ras_empty;
    logic               w_ras_full;

    assign w_ras_en    = (r_state == c_st_run);
    assign w_ras_empty = (r_ras_cnt == '0);
    assign w_ras_full  = (r_ras_cnt == c_cnt_w'(RAS_DEPTH));
    assign w_top_inc   = (r_ras_top == c_ptr_w'(RAS_DEPTH - 1)) ? '0
                                                                : r_ras_top + c_ptr_w'(1);
    assign w_top_dec   = (r_ras_top == '0) ? c_ptr_w'(RAS_DEPTH - 1)
                                           : r_ras_top - c_ptr_w'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ras_top <= '0;
            r_ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_ras_en) begin
            if (i_ras_push && i_ras_pop && !w_ras_empty) begin
                // Return followed by call: replace the top in place.
                r_ras[r_ras_top] <= o_ret_data;
            end else if (i_ras_push) begin
                r_ras[w_top_inc] <= o_ret_data;
                r_ras_top        <= w_top_inc;
                if (!w_ras_full) r_ras_cnt <= r_ras_cnt + c_cnt_w'(1);
            end else if (i_ras_pop && !w_ras_empty) begin
                r_ras_top <= w_top_dec;
                r_ras_cnt <= r_ras_cnt - c_cnt_w'(1);
            end
        end
    end

    assign o_ras_valid = !w_ras_empty;
    assign o_ras_top   = w_ras_empty ? '0 : r_ras[r_ras_top];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn && (r_state == c_st_run) && (i_op > c_op_trap)) begin
            $error("pc_fetch_unit: illegal op %0d treated as stop", i_op);
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised successor to the single-cycle program counter. It generates the fetch address and hands it to instruction memory over a valid/ready handshake. It applies JAL/JALR/branch/trap redirects, checks targets for misalignment and halts on a misaligned target, and keeps a small return-address stack (RAS) for the decoder. It sits between decode/execute and the instruction-memory request port.

Parameters:
XLEN, 32, data and address width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
IALIGN, 32, instruction alignment in bits; 32 means target[1:0] must be 0, 16 means target[0] must be 0
RAS_DEPTH, 4, RAS entries (>=2)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_op  in  3  0 Stop, 1 Incr, 2 JAL, 3 JALR, 4 Branch, 5 Trap, 6-7 illegal
i_br_taken  in  1  branch outcome, used only with op Branch
i_imm_data  in  XLEN  sign-extended immediate
i_rs1_data  in  XLEN  rs1 operand for JALR
i_trap_vec  in  XLEN  trap handler address
i_ras_push  in  1  push o_ret_data onto the RAS (call hint)
i_ras_pop  in  1  pop the RAS (return hint)
o_req_valid  out  1  fetch request valid
i_req_ready  in  1  instruction memory accepts the request
o_pc  out  XLEN  current PC / fetch address
o_ret_data  out  XLEN  o_pc + 4
o_imm_data  out  XLEN  o_pc + i_imm_data
o_misalign  out  1  misaligned-target flag (sticky)
o_misalign_addr  out  XLEN  offending target address
o_ras_top  out  XLEN  top RAS entry
o_ras_valid  out  1  RAS not empty

Behaviour:
- Reset (async assert, sync release): pc=RESET_VECTOR, state=S_BOOT, o_req_valid=0, o_misalign=0, o_misalign_addr=0, RAS count=0, o_ras_valid=0, o_ras_top=0.
- States:
  - S_BOOT: lasts exactly 1 cycle after reset release; always moves to S_RUN.
  - S_RUN: o_req_valid=1.
  - S_HALT: o_req_valid=0, pc held.
- Target computation (all modulo 2^XLEN):
  - JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - Branch taken: pc+imm.
  - Trap: i_trap_vec.
- In S_RUN, by op:
  - Stop: pc held.
  - Incr: pc<=pc+4 only when i_req_ready=1, else held.
  - Branch not taken: treated as Incr.
  - JAL / JALR / Branch taken / Trap: redirect applied next cycle regardless of i_req_ready; an outstanding request is abandoned.
- Misalignment check on JAL, JALR and Branch-taken targets:
  - Misaligned: pc held, o_misalign<=1, o_misalign_addr<=target, state<=S_HALT.
  - Trap targets are not checked.
- In S_HALT:
  - Only Trap acts: pc<=i_trap_vec, o_misalign<=0, state<=S_RUN.
  - All other ops are ignored.
- Illegal op (6/7): behaves as Stop; simulation-only $error.
- o_ret_data and o_imm_data are combinational from the registered pc.
- RAS: circular buffer of RAS_DEPTH entries with a top pointer and a count (0..RAS_DEPTH).
  - Push: write o_ret_data at top+1; count saturates at RAS_DEPTH; on overflow the oldest entry is overwritten.
  - Pop: top-1, count-1. Pop when empty is a no-op.
  - Push and pop in the same cycle: overwrite the top entry with o_ret_data; count unchanged (if empty, acts as push).
  - Push/pop are ignored in S_BOOT and S_HALT.
  - o_ras_top = entry[top] when count>0, else 0.
- Reset asserted mid-operation: all state returns to reset values immediately, with no dependence on clk.

Test Plan:
1. Reset release with RESET_VECTOR=0x100, op=Incr, i_req_ready=1 -> cycle 1 o_req_valid=0, pc=0x100; then pc=0x100, 0x104, 0x108 on consecutive cycles.
2. Incr with i_req_ready held 0 for 3 cycles at pc=0x200 -> pc stays 0x200, o_req_valid=1; ready=1 -> pc=0x204.
3. pc=0x300, JALR with rs1=0x1001, imm=0x0F -> next pc=0x1010; JALR with rs1=0x1001, imm=0x01 -> target 0x1002, o_misalign=1, addr=0x1002, o_req_valid=0; then Trap with vec=0x80 -> pc=0x80, o_misalign=0.
4. Branch at pc=0x400, imm=-8: taken -> pc=0x3F8; not taken with ready=0 -> pc held at 0x400.
5. RAS_DEPTH=4: push at pc=0x10,0x20,0x30,0x40,0x50 -> o_ras_top=0x54, count 4; four pops -> tops 0x44, 0x34, 0x24, then o_ras_valid=0; a fifth pop leaves count at 0.
6. Simultaneous push+pop at pc=0x60 with top=0x24 -> top becomes 0x64, count unchanged; reset asserted mid-sequence -> o_ras_valid=0, pc=RESET_VECTOR asynchronously.
